// File: rtl/therm_sampler.sv
// Thermometer comparator sampler: synchronizes raw comparator bits, strobes them
// every DIV clocks, repairs bubbles and hands a clean code to the encoder.
module therm_sampler #(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] comp,
    input  logic        ready,
    input  logic        ovr_clr,
    output logic [14:0] ith,
    output logic        valid,
    output logic        overrun,
    output logic [7:0]  bubble_cnt
);

    localparam logic [7:0] CNT_MAX = 8'(DIV - 1);

    logic [14:0] s1_q, s1_d;
    logic [14:0] s2_q, s2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [14:0] ith_q, ith_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  bubble_cnt_q, bubble_cnt_d;

    logic        strobe;
    logic [16:0] r_ext;
    logic [14:0] filt;
    logic [3:0]  ones;
    logic [14:0] code;
    logic [15:0] r_wide;
    logic        legal;

    always_comb begin
        strobe = en && (cnt_q == CNT_MAX);

        // Boundary bits: below bit 0 reads as 1, above bit 14 reads as 0.
        r_ext = {1'b0, s2_q, 1'b1};
        filt  = '0;
        ones  = '0;
        code  = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            filt[i] = (r_ext[i] & r_ext[i+1]) | (r_ext[i] & r_ext[i+2]) |
                      (r_ext[i+1] & r_ext[i+2]);
            ones    = ones + 4'(filt[i]);
        end
        for (int unsigned i = 0; i < 15; i++) begin
            code[i] = (4'(i) < ones);
        end

        r_wide = {1'b0, s2_q};
        legal  = ((r_wide & (r_wide + 16'd1)) == '0);
    end

    always_comb begin
        s1_d         = comp;
        s2_d         = s1_q;
        cnt_d        = '0;
        ith_d        = ith_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        bubble_cnt_d = bubble_cnt_q;

        if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 8'd1;
        end

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        if (strobe) begin
            if (!legal && (bubble_cnt_q != 8'hFF)) begin
                bubble_cnt_d = bubble_cnt_q + 8'd1;
            end
            if (!valid_q || ready) begin
                ith_d   = code;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            cnt_q        <= '0;
            ith_q        <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cnt_q        <= cnt_d;
            ith_q        <= ith_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ith        = ith_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_therm_sampler.sv
// Directed bench for therm_sampler: cycle-level reference plus a scoreboard of
// expected codes that is drained on every observed handshake.
module tb_therm_sampler;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [14:0] comp = '0;
    logic        ready = 1'b1;
    logic        ovr_clr = 1'b0;
    logic [14:0] ith;
    logic        valid;
    logic        overrun;
    logic [7:0]  bubble_cnt;

    int checks = 0;
    int failures = 0;

    therm_sampler #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .comp       (comp),
        .ready      (ready),
        .ovr_clr    (ovr_clr),
        .ith        (ith),
        .valid      (valid),
        .overrun    (overrun),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] exp_code(input logic [14:0] r);
        int n = 0;
        logic lo, hi;
        for (int i = 0; i < 15; i++) begin
            lo = (i == 0)  ? 1'b1 : r[i-1];
            hi = (i == 14) ? 1'b0 : r[i+1];
            if ((int'(lo) + int'(r[i]) + int'(hi)) >= 2) n++;
        end
        return 15'((32'd1 << n) - 32'd1);
    endfunction

    function automatic bit is_legal(input logic [14:0] r);
        return r == 15'((32'd1 << $countones(r)) - 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboard
    logic [14:0] m_s1 = '0, m_s2 = '0;
    int          m_cnt = 0;
    logic        m_valid = 1'b0, m_ovr = 1'b0;
    logic [7:0]  m_bub = '0;
    logic [14:0] sb_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_s1 <= '0; m_s2 <= '0; m_cnt <= 0;
            m_valid <= 1'b0; m_ovr <= 1'b0; m_bub <= '0;
            sb_q.delete();
        end else begin
            m_s1  <= comp;
            m_s2  <= m_s1;
            m_cnt <= !en ? 0 : ((m_cnt == int'(DIV) - 1) ? 0 : m_cnt + 1);
            if (ovr_clr) m_ovr <= 1'b0;
            if (en && m_cnt == int'(DIV) - 1) begin
                if (!is_legal(m_s2) && m_bub != 8'hFF) m_bub <= m_bub + 8'd1;
                if (!m_valid || ready) begin
                    m_valid <= 1'b1;
                    sb_q.push_back(exp_code(m_s2));
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Monitor: continuous state compare, scoreboard pop, hold check
    logic        prev_hold = 1'b0, prev_rst = 1'b1;
    logic [14:0] prev_ith = '0;
    logic [14:0] exp_ith;

    always @(negedge clk) begin
        chk("valid", 32'(valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
        if (prev_hold && !prev_rst) chk("ith_hold", 32'(ith), 32'(prev_ith));
        if (valid && ready && !rst) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_ith = sb_q.pop_front();
                chk("ith_sb", 32'(ith), 32'(exp_ith));
            end
        end
        prev_hold = valid && !ready;
        prev_ith  = ith;
        prev_rst  = rst;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          pulses;
    int          k;
    logic        last_v;
    logic [14:0] held;

    initial begin
        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_ith", 32'(ith), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_bubble", 32'(bubble_cnt), 32'h0);

        // Legal code held: one-cycle valid pulse every DIV cycles
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; comp = 15'h007F; ready = 1'b1;
        step(8);
        pulses = 0; last_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (valid) pulses++;
            if (valid && last_v) chk("valid_width", 32'd2, 32'd1);
            last_v = valid;
        end
        chk("valid_pulses", 32'(pulses), 32'd4);
        chk("legal_ith", 32'(ith), 32'h007F);
        chk("legal_bubble", 32'(bubble_cnt), 32'h0);

        // Single bubble at bit 5: repaired code has six ones
        step(1);
        comp = 15'b000000001011111;
        step(16);
        @(negedge clk);
        chk("bubble_ith", 32'(ith), 32'h003F);
        chk("bubble_cnt_grew", 32'(bubble_cnt != 8'd0), 32'd1);

        // Isolated high bit at 5 is filtered away
        step(1);
        comp = 15'b000000000100111;
        step(16);
        @(negedge clk);
        chk("isolated_ith", 32'(ith), 32'h0007);

        // Back-pressure across two strobes, then clear
        step(1);
        comp = 15'h007F;
        step(8);
        ready = 1'b0;
        k = 0;
        while (!valid && k < 3 * int'(DIV)) begin
            step(1);
            k++;
        end
        chk("bp_valid_seen", 32'(valid), 32'd1);
        held = ith;
        step(2 * int'(DIV) + 1);
        @(negedge clk);
        chk("bp_overrun", 32'(overrun), 32'd1);
        chk("bp_ith_held", 32'(ith), 32'(held));
        step(1);
        ovr_clr = 1'b1; ready = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Overrun event and clear in the same cycle: set wins
        step(1);
        ready = 1'b0;
        k = 0;
        while (!valid && k < 3 * int'(DIV)) begin
            step(1);
            k++;
        end
        k = 0;
        while (m_cnt != int'(DIV) - 1 && k < 2 * int'(DIV)) begin
            step(1);
            k++;
        end
        chk("coinc_align", 32'(m_cnt), 32'(DIV - 1));
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        @(negedge clk);
        chk("coinc_overrun", 32'(overrun), 32'd1);

        // Reset one cycle before a strobe, held through the strobe cycle
        step(1);
        k = 0;
        while (m_cnt != int'(DIV) - 2 && k < 2 * int'(DIV)) begin
            step(1);
            k++;
        end
        rst = 1'b1; ready = 1'b1; ovr_clr = 1'b1;
        comp = 15'b000000001011111;
        step(2);
        rst = 1'b0; ovr_clr = 1'b0;
        @(negedge clk);
        chk("rst2_ith", 32'(ith), 32'h0);
        chk("rst2_valid", 32'(valid), 32'h0);
        chk("rst2_overrun", 32'(overrun), 32'h0);
        chk("rst2_bubble", 32'(bubble_cnt), 32'h0);
        k = 1;
        while (!valid && k < 4 * int'(DIV)) begin
            @(negedge clk);
            k++;
        end
        chk("first_valid_latency", 32'(k), 32'(DIV + 1));

        // Saturation of the bubble counter
        step(300 * int'(DIV) + 8);
        @(negedge clk);
        chk("bubble_sat", 32'(bubble_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
